// File: rtl/preif_fetch.sv
// Instruction fetch stage ahead of IF: issues one outstanding memory request at a time,
// follows redirects and reports misaligned fetch addresses as an exception.
module preif_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int unsigned ADEL_BIT = 4
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [3:0]  stall_i,
    input  logic        branch_enable_i,
    input  logic [31:0] branch_target_i,
    input  logic        exception_i,
    input  logic [31:0] exception_target_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] postif_pc_o,
    output logic [31:0] postif_inst_o,
    output logic [31:0] postif_exception_type_o,
    output logic        postif_inst_ren_o,
    output logic        postif_inst_ok_o,
    output logic        postif_inst_valid_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_discard;
    logic        r_adel_done;

    logic        w_stall;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_handshake;
    logic        w_data_ret;
    logic [31:0] w_pc_next;
    logic        w_pc_next_ok;
    logic        w_deliver;
    logic        w_adel;
    logic [31:0] w_adel_flags;

    assign w_stall      = |stall_i;
    assign w_redirect   = exception_i | branch_enable_i;
    assign w_target     = exception_i ? exception_target_i : branch_target_i;
    assign w_handshake  = (r_state == StReq) & inst_addr_ok_i;
    assign w_data_ret   = (r_state == StWait) & inst_data_ok_i;
    assign w_pc_next    = w_redirect  ? w_target :
                          w_handshake ? r_pc + 32'd4 : r_pc;
    assign w_pc_next_ok = (w_pc_next[1:0] == 2'b00);
    // A return that coincides with a redirect belongs to the abandoned path.
    assign w_deliver    = w_data_ret & ~r_discard & ~w_redirect;
    assign w_adel       = (r_state == StIdle) & (r_pc[1:0] != 2'b00) & ~r_adel_done & ~w_stall;
    assign w_adel_flags = 32'd1 << ADEL_BIT;

    assign inst_addr_o       = r_pc;
    assign postif_inst_ren_o = inst_req_o & inst_addr_ok_i;
    assign postif_inst_ok_o  = inst_data_ok_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Transitions look at the next fetch PC so REQ never presents a misaligned address.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (!w_stall && w_pc_next_ok) w_state_next = StReq;
            end
            StReq: begin
                if (w_handshake)        w_state_next = StWait;
                else if (!w_pc_next_ok) w_state_next = StIdle;
            end
            StWait: begin
                if (inst_data_ok_i) begin
                    w_state_next = (!w_stall && w_pc_next_ok) ? StReq : StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        inst_req_o = (r_state == StReq);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_pc        <= RESET_PC;
            r_req_pc    <= 32'd0;
            r_discard   <= 1'b0;
            r_adel_done <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_handshake) r_req_pc <= r_pc;
            if (w_data_ret) begin
                r_discard <= 1'b0;
            end else if (w_redirect && ((r_state == StWait) || w_handshake)) begin
                r_discard <= 1'b1;
            end
            if (w_redirect)  r_adel_done <= 1'b0;
            else if (w_adel) r_adel_done <= 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            postif_inst_valid_o     <= 1'b0;
            postif_pc_o             <= 32'd0;
            postif_inst_o           <= 32'd0;
            postif_exception_type_o <= 32'd0;
        end else begin
            postif_inst_valid_o <= w_deliver | w_adel;
            if (w_deliver) begin
                postif_pc_o             <= r_req_pc;
                postif_inst_o           <= inst_rdata_i;
                postif_exception_type_o <= 32'd0;
            end else if (w_adel) begin
                postif_pc_o             <= r_pc;
                postif_inst_o           <= 32'd0;
                postif_exception_type_o <= w_adel_flags;
            end
        end
    end

endmodule

// File: tb/tb_preif_fetch.sv
// Directed bench for preif_fetch: scoreboard queue of expected deliveries checked by a
// negedge monitor, plus direct checks of request address, handshake outputs and reset.
module tb_preif_fetch;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [3:0]  stall_i;
    logic        branch_enable_i;
    logic [31:0] branch_target_i;
    logic        exception_i;
    logic [31:0] exception_target_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic [31:0] postif_pc_o;
    logic [31:0] postif_inst_o;
    logic [31:0] postif_exception_type_o;
    logic        postif_inst_ren_o;
    logic        postif_inst_ok_o;
    logic        postif_inst_valid_o;

    int n_vec = 0;
    int n_err = 0;
    logic [95:0] exp_q[$];

    preif_fetch dut (
        .clock_i                 (clock_i),
        .reset_i                 (reset_i),
        .stall_i                 (stall_i),
        .branch_enable_i         (branch_enable_i),
        .branch_target_i         (branch_target_i),
        .exception_i             (exception_i),
        .exception_target_i      (exception_target_i),
        .inst_req_o              (inst_req_o),
        .inst_addr_o             (inst_addr_o),
        .inst_addr_ok_i          (inst_addr_ok_i),
        .inst_data_ok_i          (inst_data_ok_i),
        .inst_rdata_i            (inst_rdata_i),
        .postif_pc_o             (postif_pc_o),
        .postif_inst_o           (postif_inst_o),
        .postif_exception_type_o (postif_exception_type_o),
        .postif_inst_ren_o       (postif_inst_ren_o),
        .postif_inst_ok_o        (postif_inst_ok_o),
        .postif_inst_valid_o     (postif_inst_valid_o)
    );

    always #5 clock_i = ~clock_i;

    // Monitor: every valid pulse must match the oldest expected delivery.
    always @(negedge clock_i) begin
        if (!reset_i && postif_inst_valid_o) begin
            logic [95:0] got;
            logic [95:0] want;
            got = {postif_pc_o, postif_inst_o, postif_exception_type_o};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got pc=%h inst=%h exc=%h, required no pulse",
                         postif_pc_o, postif_inst_o, postif_exception_type_o);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_err++;
                    $display("FAIL delivery: got pc=%h inst=%h exc=%h, required pc=%h inst=%h exc=%h",
                             got[95:64], got[63:32], got[31:0],
                             want[95:64], want[63:32], want[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic wait_req(input string name, input logic [31:0] addr);
        int k;
        k = 0;
        while (!inst_req_o && k < 20) begin
            tick();
            k++;
        end
        n_vec++;
        if (!inst_req_o) begin
            n_err++;
            $display("FAIL %s: no request within 20 cycles, required req at %h", name, addr);
        end else if (inst_addr_o !== addr) begin
            n_err++;
            $display("FAIL %s: got req addr %h, required %h", name, inst_addr_o, addr);
        end
    endtask

    // Full transaction: addr_ok in the REQ cycle, data_ok one cycle later.
    task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] rdata,
                         input bit expect_valid);
        wait_req(name, addr);
        inst_addr_ok_i = 1'b1;
        #1;
        check({name, "_ren"}, {31'd0, postif_inst_ren_o}, 32'd1);
        tick();
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = rdata;
        #1;
        check({name, "_ok"}, {31'd0, postif_inst_ok_o}, 32'd1);
        if (expect_valid) exp_q.push_back({addr, rdata, 32'd0});
        tick();
        inst_data_ok_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        reset_i            = 1'b1;
        stall_i            = 4'd0;
        branch_enable_i    = 1'b0;
        branch_target_i    = 32'd0;
        exception_i        = 1'b0;
        exception_target_i = 32'd0;
        inst_addr_ok_i     = 1'b0;
        inst_data_ok_i     = 1'b0;
        inst_rdata_i       = 32'd0;
        tick();
        tick();
        check("rst_req", {31'd0, inst_req_o}, 32'd0);
        check("rst_addr", inst_addr_o, 32'hBFC0_0000);
        check("rst_pc_o", postif_pc_o, 32'd0);
        check("rst_inst_o", postif_inst_o, 32'd0);
        check("rst_exc_o", postif_exception_type_o, 32'd0);
        check("rst_valid", {31'd0, postif_inst_valid_o}, 32'd0);

        // Reset release then basic fetch
        reset_i = 1'b0;
        tick();
        check("first_edge_req", {31'd0, inst_req_o}, 32'd1);
        fetch("boot", 32'hBFC0_0000, 32'h2408_0001, 1'b1);

        // Branch while in WAIT discards the return
        wait_req("seq_req", 32'hBFC0_0004);
        inst_addr_ok_i = 1'b1;
        tick();
        inst_addr_ok_i  = 1'b0;
        check("wait_no_req", {31'd0, inst_req_o}, 32'd0);
        branch_enable_i = 1'b1;
        branch_target_i = 32'h8000_0100;
        tick();
        branch_enable_i = 1'b0;
        inst_data_ok_i  = 1'b1;
        inst_rdata_i    = 32'hDEAD_BEEF;
        tick();
        inst_data_ok_i  = 1'b0;
        wait_req("after_branch", 32'h8000_0100);

        // Exception beats branch in the same cycle
        exception_i        = 1'b1;
        exception_target_i = 32'hBFC0_0380;
        branch_enable_i    = 1'b1;
        branch_target_i    = 32'h8000_0000;
        tick();
        exception_i     = 1'b0;
        branch_enable_i = 1'b0;
        check("exc_prio_addr", inst_addr_o, 32'hBFC0_0380);
        fetch("handler", 32'hBFC0_0380, 32'h1111_1111, 1'b1);

        // Branch coinciding with data_ok discards that return; target is misaligned
        wait_req("seq_req2", 32'hBFC0_0384);
        inst_addr_ok_i = 1'b1;
        tick();
        inst_addr_ok_i  = 1'b0;
        inst_data_ok_i  = 1'b1;
        inst_rdata_i    = 32'h5555_5555;
        branch_enable_i = 1'b1;
        branch_target_i = 32'h8000_0102;
        exp_q.push_back({32'h8000_0102, 32'd0, 32'h0000_0010});
        tick();
        inst_data_ok_i  = 1'b0;
        branch_enable_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("adel_no_req", {31'd0, inst_req_o}, 32'd0);
            tick();
        end
        branch_enable_i = 1'b1;
        branch_target_i = 32'h8000_0200;
        tick();
        branch_enable_i = 1'b0;
        wait_req("adel_resume", 32'h8000_0200);

        // Stall during WAIT: one delivery, then no request until stall clears
        inst_addr_ok_i = 1'b1;
        tick();
        inst_addr_ok_i = 1'b0;
        stall_i        = 4'b0100;
        tick();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h2222_2222;
        exp_q.push_back({32'h8000_0200, 32'h2222_2222, 32'd0});
        tick();
        inst_data_ok_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_no_req", {31'd0, inst_req_o}, 32'd0);
            tick();
        end
        stall_i = 4'd0;
        tick();
        check("stall_resume_req", {31'd0, inst_req_o}, 32'd1);
        check("stall_resume_addr", inst_addr_o, 32'h8000_0204);

        // Reset during WAIT with a late data_ok after release
        inst_addr_ok_i = 1'b1;
        tick();
        inst_addr_ok_i = 1'b0;
        #1;
        reset_i = 1'b1;
        #1;
        check("midrst_req", {31'd0, inst_req_o}, 32'd0);
        check("midrst_addr", inst_addr_o, 32'hBFC0_0000);
        check("midrst_valid", {31'd0, postif_inst_valid_o}, 32'd0);
        tick();
        reset_i        = 1'b0;
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h3333_3333;
        tick();
        inst_data_ok_i = 1'b0;
        check("postrst_req", {31'd0, inst_req_o}, 32'd1);
        fetch("reboot", 32'hBFC0_0000, 32'h4444_4444, 1'b1);

        // PC wraps from FFFF_FFFC to 0
        wait_req("pre_wrap", 32'hBFC0_0004);
        branch_enable_i = 1'b1;
        branch_target_i = 32'hFFFF_FFFC;
        tick();
        branch_enable_i = 1'b0;
        fetch("wrap_top", 32'hFFFF_FFFC, 32'h6666_6666, 1'b1);
        wait_req("wrap_zero", 32'h0000_0000);

        tick();
        tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
